// File: rtl/ga_pkg.sv
// Shared definitions for the GA engine: FSM state encoding, bit offsets of the
// fields carved out of the 64-bit RNG word, and the crossover/mutation datapath.
package ga_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StEval,
    StCheck,
    StBreed,
    StDone
  } ga_state_e;

  // Field offsets within the per-cycle 64-bit random word (LSB first).
  localparam int unsigned RndA0 = 0;
  localparam int unsigned RndA1 = 8;
  localparam int unsigned RndB0 = 16;
  localparam int unsigned RndB1 = 24;
  localparam int unsigned RndXp = 32;
  localparam int unsigned RndM1 = 40;
  localparam int unsigned RndM2 = 48;
  localparam int unsigned RndE1 = 56;
  localparam int unsigned RndE2 = 60;

  // One child: bits below the crossover point come from 'other', the rest from
  // 'keep'; bit 'mbit' flips when the masked chance bits are all zero.
  // Works at the maximum chromosome width; callers truncate.
  function automatic logic [31:0] ga_child(input logic [31:0] keep,
                                           input logic [31:0] other,
                                           input logic [4:0]  xp,
                                           input logic [4:0]  mbit,
                                           input logic [3:0]  ebits,
                                           input logic [3:0]  emask);
    logic [31:0] mask;
    logic [31:0] child;
    mask  = (32'd1 << xp) - 32'd1;
    child = (keep & ~mask) | (other & mask);
    if ((ebits & emask) == 4'd0) child[mbit] = ~child[mbit];
    return child;
  endfunction

endpackage

// File: rtl/ga_rng.sv
// Pair of xorshift32 generators (13/17/5) giving 64 random bits per cycle.
// Ports: clk, reset (sync, active-high); load reseeds from seed / ~seed
// (zero replaced by 1); advance steps both generators; rnd = {gen1, gen0}.
module ga_rng (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [63:0] rnd
);

  logic [31:0] s0_q, s1_q;
  logic [31:0] seed_lo, seed_hi;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // An all-zero state would lock xorshift at zero forever.
  assign seed_lo = (seed == 32'd0) ? 32'd1 : seed;
  assign seed_hi = (~seed == 32'd0) ? 32'd1 : ~seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q <= 32'd0;
      s1_q <= 32'd0;
    end else if (load) begin
      s0_q <= seed_lo;
      s1_q <= seed_hi;
    end else if (advance) begin
      s0_q <= xorshift32(s0_q);
      s1_q <= xorshift32(s1_q);
    end
  end

  assign rnd = {s1_q, s0_q};

endmodule

// File: rtl/ga_engine.sv
// Genetic-algorithm engine with an external fitness evaluator.
// Ports: clk/reset (sync, active-high); start/seed/gens/target_en/target_fit
// run control sampled on an accepted start; eval_valid/eval_chrom/eval_ready
// request port; fit_valid/fit in-order responses; busy/done/hit_target status;
// gen_count, best, best_fit results of the run.
module ga_engine import ga_pkg::*; #(
  parameter int unsigned POP_SIZE    = 32,
  parameter int unsigned CHROM_WIDTH = 16,
  parameter int unsigned FIT_WIDTH   = 51,
  parameter int unsigned MUT_SHIFT   = 4,
  parameter int unsigned ELITISM     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            seed,
  input  logic [15:0]            gens,
  input  logic                   target_en,
  input  logic [FIT_WIDTH-1:0]   target_fit,
  output logic                   eval_valid,
  output logic [CHROM_WIDTH-1:0] eval_chrom,
  input  logic                   eval_ready,
  input  logic                   fit_valid,
  input  logic [FIT_WIDTH-1:0]   fit,
  output logic                   busy,
  output logic                   done,
  output logic                   hit_target,
  output logic [15:0]            gen_count,
  output logic [CHROM_WIDTH-1:0] best,
  output logic [FIT_WIDTH-1:0]   best_fit
);

  localparam int unsigned IW   = $clog2(POP_SIZE);
  localparam int unsigned CWL  = $clog2(CHROM_WIDTH);
  localparam int unsigned CntW = IW + 1;
  localparam logic [CntW-1:0] LastIdx  = CntW'(POP_SIZE - 1);
  localparam logic [CntW-1:0] PopCnt   = CntW'(POP_SIZE);
  localparam logic [CntW-1:0] LastPair = CntW'(POP_SIZE / 2 - 1);
  localparam logic [3:0]      EMask    = 4'((32'd1 << MUT_SHIFT) - 32'd1);

  ga_state_e state_q, state_d;

  logic [CntW-1:0]        cnt_q;   // INIT slot, EVAL issue index, BREED pair
  logic [CntW-1:0]        resp_q;  // EVAL response index
  logic [15:0]            gens_q, gen_count_q;
  logic                   tgt_en_q, hit_q, first_q;
  logic [FIT_WIDTH-1:0]   tgt_fit_q, best_fit_q;
  logic [CHROM_WIDTH-1:0] best_q;

  logic [CHROM_WIDTH-1:0] pop_q  [POP_SIZE];
  logic [CHROM_WIDTH-1:0] next_q [POP_SIZE];
  logic [FIT_WIDTH-1:0]   fitv_q [POP_SIZE];

  logic [63:0]            rnd;
  logic                   start_ok, issue, resp_ok, resp_last, better, target_ok;
  logic [15:0]            gen_next;
  logic [CHROM_WIDTH-1:0] resp_chrom, par_a, par_b, child1, child2;
  logic [IW-1:0]          ia0, ia1, ib0, ib1, pair_lo, pair_hi;
  logic [31:0]            c1_raw, c2_raw;
  logic                   unused_bits;

  ga_rng u_rng (
    .clk     (clk),
    .reset   (reset),
    .load    (start_ok),
    .seed    (seed),
    .advance (busy),
    .rnd     (rnd)
  );

  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);
  assign hit_target = hit_q;
  assign gen_count  = gen_count_q;
  assign best       = best_q;
  assign best_fit   = best_fit_q;

  assign start_ok   = start && ((state_q == StIdle) || (state_q == StDone));
  assign eval_valid = (state_q == StEval) && (cnt_q < PopCnt);
  assign eval_chrom = eval_valid ? pop_q[cnt_q[IW-1:0]] : '0;
  assign issue      = eval_valid && eval_ready;
  // A response is outstanding if already issued or being issued this cycle.
  assign resp_ok    = (state_q == StEval) && fit_valid && ((resp_q < cnt_q) || issue);
  assign resp_last  = resp_ok && (resp_q == LastIdx);
  assign resp_chrom = pop_q[resp_q[IW-1:0]];
  assign better     = first_q || (fit > best_fit_q);
  assign gen_next   = gen_count_q + 16'd1;
  assign target_ok  = tgt_en_q && (best_fit_q >= tgt_fit_q);

  // Breeding datapath for the current pair.
  assign ia0     = rnd[RndA0 +: IW];
  assign ia1     = rnd[RndA1 +: IW];
  assign ib0     = rnd[RndB0 +: IW];
  assign ib1     = rnd[RndB1 +: IW];
  assign par_a   = (fitv_q[ia1] > fitv_q[ia0]) ? pop_q[ia1] : pop_q[ia0];
  assign par_b   = (fitv_q[ib1] > fitv_q[ib0]) ? pop_q[ib1] : pop_q[ib0];
  assign c1_raw  = ga_child(32'(par_a), 32'(par_b), 5'(rnd[RndXp +: CWL]),
                            5'(rnd[RndM1 +: CWL]), rnd[RndE1 +: 4], EMask);
  assign c2_raw  = ga_child(32'(par_b), 32'(par_a), 5'(rnd[RndXp +: CWL]),
                            5'(rnd[RndM2 +: CWL]), rnd[RndE2 +: 4], EMask);
  assign child1  = ((ELITISM != 0) && (cnt_q == '0)) ? best_q : c1_raw[CHROM_WIDTH-1:0];
  assign child2  = c2_raw[CHROM_WIDTH-1:0];
  assign pair_lo = IW'({cnt_q, 1'b0});
  assign pair_hi = {pair_lo[IW-1:1], 1'b1};

  assign unused_bits = ^{rnd, c1_raw, c2_raw};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_ok) state_d = StInit;
      StInit:         if (cnt_q == LastIdx) state_d = StEval;
      StEval:         if (resp_last) state_d = StCheck;
      StCheck:        state_d = (target_ok || (gen_next == gens_q)) ? StDone : StBreed;
      StBreed:        if (cnt_q == LastPair) state_d = StEval;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      resp_q      <= '0;
      gens_q      <= '0;
      gen_count_q <= '0;
      tgt_en_q    <= 1'b0;
      tgt_fit_q   <= '0;
      hit_q       <= 1'b0;
      first_q     <= 1'b0;
      best_q      <= '0;
      best_fit_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        gens_q      <= (gens == 16'd0) ? 16'd1 : gens;
        tgt_en_q    <= target_en;
        tgt_fit_q   <= target_fit;
        gen_count_q <= '0;
        hit_q       <= 1'b0;
        first_q     <= 1'b1;
        best_q      <= '0;
        best_fit_q  <= '0;
        cnt_q       <= '0;
      end
      case (state_q)
        StInit: begin
          cnt_q  <= (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
          resp_q <= '0;
        end
        StEval: begin
          if (issue) cnt_q <= cnt_q + 1'b1;
          if (resp_ok) begin
            resp_q <= resp_q + 1'b1;
            if (better) begin
              best_q     <= resp_chrom;
              best_fit_q <= fit;
              first_q    <= 1'b0;
            end
          end
        end
        StCheck: begin
          gen_count_q <= gen_next;
          cnt_q       <= '0;
          if (target_ok) hit_q <= 1'b1;
        end
        StBreed: begin
          cnt_q  <= (cnt_q == LastPair) ? '0 : cnt_q + 1'b1;
          resp_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Data arrays carry no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state_q == StInit) pop_q[cnt_q[IW-1:0]] <= rnd[CHROM_WIDTH-1:0];
    if (resp_ok) fitv_q[resp_q[IW-1:0]] <= fit;
    if (state_q == StBreed) begin
      next_q[pair_lo] <= child1;
      next_q[pair_hi] <= child2;
      if (cnt_q == LastPair) begin
        for (int n = 0; n < POP_SIZE; n++) pop_q[n] <= next_q[n];
        // The final pair is still being written into next_q this cycle.
        pop_q[pair_lo] <= child1;
        pop_q[pair_hi] <= child2;
      end
    end
  end

endmodule

// File: tb/tb_ga_engine.sv
module tb_ga_engine;

  localparam int unsigned P  = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned FW = 16;
  localparam int unsigned MS = 2;
  localparam int unsigned EL = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   seed = '0;
  logic [15:0]   gens = '0;
  logic          target_en = 1'b0;
  logic [FW-1:0] target_fit = '0;
  logic          eval_valid;
  logic [CW-1:0] eval_chrom;
  logic          eval_ready = 1'b0;
  logic          fit_valid = 1'b0;
  logic [FW-1:0] fit = '0;
  logic          busy, done, hit_target;
  logic [15:0]   gen_count;
  logic [CW-1:0] best;
  logic [FW-1:0] best_fit;

  ga_engine #(
    .POP_SIZE    (P),
    .CHROM_WIDTH (CW),
    .FIT_WIDTH   (FW),
    .MUT_SHIFT   (MS),
    .ELITISM     (EL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .gens       (gens),
    .target_en  (target_en),
    .target_fit (target_fit),
    .eval_valid (eval_valid),
    .eval_chrom (eval_chrom),
    .eval_ready (eval_ready),
    .fit_valid  (fit_valid),
    .fit        (fit),
    .busy       (busy),
    .done       (done),
    .hit_target (hit_target),
    .gen_count  (gen_count),
    .best       (best),
    .best_fit   (best_fit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]   r0, r1;
  bit            m_busy = 0;
  logic [CW-1:0] mpop [P];
  logic [CW-1:0] mnext [P];
  logic [FW-1:0] mfit [P];
  logic [CW-1:0] mbest;
  logic [FW-1:0] mbest_fit;
  bit            mfirst;
  int            mgen;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] nz(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

  function automatic logic [FW-1:0] fitfn(input int mode, input logic [CW-1:0] c);
    case (mode)
      0:       return FW'(c);
      1:       return FW'($countones(c));
      default: return FW'((int'(c) * int'(c) + 3 * int'(c)) % 1009);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the RNG model steps on every edge where the run is busy.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_busy) begin
      r0 = xs(r0);
      r1 = xs(r1);
    end
  endtask

  task automatic breed_pair(input int k);
    logic [63:0]   rnd;
    logic [CW-1:0] pa, pb, c1, c2;
    int a0, a1, b0, b1, p, m1, m2, e1, e2;
    rnd = {r1, r0};
    a0 = int'(rnd[7:0]) % P;   a1 = int'(rnd[15:8]) % P;
    b0 = int'(rnd[23:16]) % P; b1 = int'(rnd[31:24]) % P;
    p  = int'(rnd[39:32]) % CW;
    m1 = int'(rnd[47:40]) % CW; m2 = int'(rnd[55:48]) % CW;
    e1 = int'(rnd[59:56]);      e2 = int'(rnd[63:60]);
    pa = (mfit[a1] > mfit[a0]) ? mpop[a1] : mpop[a0];
    pb = (mfit[b1] > mfit[b0]) ? mpop[b1] : mpop[b0];
    for (int b = 0; b < CW; b++) begin
      c1[b] = (b < p) ? pb[b] : pa[b];
      c2[b] = (b < p) ? pa[b] : pb[b];
    end
    if (e1 % (1 << MS) == 0) c1[m1] = ~c1[m1];
    if (e2 % (1 << MS) == 0) c2[m2] = ~c2[m2];
    if (EL != 0 && k == 0) c1 = mbest;
    mnext[2*k]   = c1;
    mnext[2*k+1] = c2;
  endtask

  // rmode: 0 ready always, 1 toggling, 2 random. lat: response latency.
  // abort_at > 0: reset the DUT at that EVAL cycle of generation 0.
  // poke: pulse start while busy during generation 1.
  task automatic run(input logic [31:0] s, input logic [15:0] g, input bit ten,
                     input logic [FW-1:0] tf, input int fmode, input int rmode,
                     input int lat, input int abort_at, input bit poke);
    logic [CW-1:0] q_chrom [$];
    int            q_due [$];
    int            issued, resp, cyc, glim;
    bit            stop, hit, rdy;
    logic [CW-1:0] c;
    logic [FW-1:0] fv;

    seed = s; gens = g; target_en = ten; target_fit = tf;
    start = 1'b1;
    tick();
    start = 1'b0;
    r0 = nz(s); r1 = nz(~s); m_busy = 1;
    mgen = 0; mfirst = 1; mbest = '0; mbest_fit = '0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_gen", 64'(gen_count), 64'd0);
    glim = (g == 16'd0) ? 1 : int'(g);

    for (int j = 0; j < P; j++) begin
      mpop[j] = r0[CW-1:0];
      tick();
    end

    stop = 0;
    while (!stop) begin
      issued = 0; resp = 0; cyc = 0;
      q_chrom.delete(); q_due.delete();
      while (resp < P) begin
        if (poke && mgen == 1 && cyc == 2) begin
          seed = ~s; start = 1'b1;
        end else start = 1'b0;
        case (rmode)
          0:       rdy = 1;
          1:       rdy = (cyc % 2 == 1);
          default: rdy = ($urandom_range(0, 1) == 1);
        endcase
        eval_ready = rdy;
        if (issued < P) begin
          chk("eval_valid", 64'(eval_valid), 64'd1);
          chk("eval_chrom", 64'(eval_chrom), 64'(mpop[issued]));
          if (issued == 0 && mgen > 0 && EL != 0)
            chk("elite_slot0", 64'(eval_chrom), 64'(mbest));
          if (rdy) begin
            q_chrom.push_back(mpop[issued]);
            q_due.push_back(cyc + lat);
            issued++;
          end
        end else chk("eval_drained", 64'(eval_valid), 64'd0);
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
          c = q_chrom.pop_front();
          void'(q_due.pop_front());
          fv = fitfn(fmode, c);
          fit_valid = 1'b1; fit = fv;
          mfit[resp] = fv;
          if (mfirst || fv > mbest_fit) begin
            mbest = c; mbest_fit = fv;
          end
          mfirst = 0;
          resp++;
        end else begin
          fit_valid = 1'b0; fit = FW'($urandom);
        end
        if (abort_at > 0 && cyc == abort_at) begin
          reset = 1'b1; fit_valid = 1'b0; start = 1'b0; m_busy = 0;
          tick();
          reset = 1'b0;
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_valid", 64'(eval_valid), 64'd0);
          fit_valid = 1'b1;  // stale in-flight response
          tick();
          fit_valid = 1'b0;
          chk("abort_idle", 64'(busy), 64'd0);
          chk("abort_done", 64'(done), 64'd0);
          return;
        end
        tick();
        cyc++;
      end
      fit_valid = 1'b0; start = 1'b0;
      // CHECK cycle
      chk("check_busy", 64'(busy), 64'd1);
      chk("check_done", 64'(done), 64'd0);
      chk("check_gen", 64'(gen_count), 64'(mgen));
      chk("check_bestfit", 64'(best_fit), 64'(mbest_fit));
      chk("check_best", 64'(best), 64'(mbest));
      hit  = ten && (mbest_fit >= tf);
      stop = hit || (mgen + 1 == glim);
      mgen++;
      tick();
      if (stop) begin
        m_busy = 0;
        chk("end_done", 64'(done), 64'd1);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_hit", 64'(hit_target), 64'(hit));
        chk("end_gen", 64'(gen_count), 64'(mgen));
        chk("end_best", 64'(best), 64'(mbest));
        chk("end_bestfit", 64'(best_fit), 64'(mbest_fit));
        chk("end_valid", 64'(eval_valid), 64'd0);
      end else begin
        for (int k = 0; k < P / 2; k++) begin
          breed_pair(k);
          tick();
        end
        for (int n = 0; n < P; n++) mpop[n] = mnext[n];
      end
    end
  endtask

  initial begin
    logic [31:0] s1, s2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(eval_valid), 64'd0);
    chk("rst_gen", 64'(gen_count), 64'd0);
    repeat (10) tick();
    fit_valid = 1'b1; fit = FW'(16'h1234);
    tick();
    fit_valid = 1'b0;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(eval_valid), 64'd0);
    chk("idle_chrom", 64'(eval_chrom), 64'd0);
    chk("idle_best", 64'(best), 64'd0);
    chk("idle_bestfit", 64'(best_fit), 64'd0);
    chk("idle_hit", 64'(hit_target), 64'd0);

    s1 = $urandom;
    s2 = $urandom;
    run(s1, 16'd1, 0, '0, 0, 0, 0, 0, 0);           // single gen, no stall
    run(s1, 16'd1, 0, '0, 0, 1, 3, 0, 0);           // stalls + latency 3
    run(s2, 16'd500, 1, FW'(CW), 1, 2, 1, 0, 0);    // popcount target
    run(s2 ^ 32'h5a5a, 16'd20, 0, '0, 2, 2, 2, 0, 1);  // elitism, start while busy
    run(s1 ^ 32'hbeef, 16'd3, 0, '0, 2, 0, 2, 3, 0);   // reset mid-EVAL
    run(s1 ^ 32'hbeef, 16'd3, 0, '0, 2, 0, 2, 0, 0);   // clean rerun
    run(32'd0, 16'd0, 0, '0, 0, 2, 0, 0, 0);        // zero seed, gens 0 -> 1

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
